// File: rtl/adder2_bist.sv
// BIST sequencer for an adder2-style DUT: sweeps {cin,b,a}, checks {cout,s}, counts mismatches.
// Build option ADDER_BIST_STOP_ON_ERR_EN: stop the sweep at the first mismatch.
//
// state | meaning
// IDLE  | reset state, vector outputs 0, waiting for start
// WAIT  | vector driven, counting down the settle time
// CHECK | compare DUT result with golden sum, advance or finish
// DONE  | sweep finished, results held until start or reset
module adder2_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 cin_o,
  input  logic [WIDTH-1:0]     s_i,
  input  logic                 cout_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_cnt,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int IW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE+1);
  localparam logic [IW-1:0] LAST     = '1;
  localparam logic [EW-1:0] ERR_MAX  = '1;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef ADDER_BIST_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   wait_cnt;
  logic [WIDTH:0]  gold;
  logic            mism;
  logic            launch;

  assign {cin_o, b_o, a_o} = idx;

  assign gold = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, cin_o};
  assign mism = ({cout_i, s_i} != gold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = WAIT;
          launch   = 1'b1;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == CNT_ONE) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (idx == LAST || (STOP_ON_ERR && mism)) state_nx = DONE;
        else                                      state_nx = WAIT;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nx = WAIT;
          launch   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      wait_cnt <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else if (launch) begin
      idx      <= '0;
      wait_cnt <= SETTLE_C;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - CNT_ONE;
    end else if (state == CHECK) begin
      if (mism) begin
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + EW'(1);
        if (err_cnt == '0)      fail_vec <= idx;
      end
      // idx only moves on when another vector follows, so DONE holds the last one driven
      if (state_nx == WAIT) begin
        idx      <= idx + IW'(1);
        wait_cnt <= SETTLE_C;
      end
    end
  end

endmodule

// File: tb/tb_adder2_bist.sv
// Bench for adder2_bist: two instances (SETTLE=1 and SETTLE=3) driving fault-injectable adder models.
module tb_adder2_bist;

  localparam int N = 32;
`ifdef ADDER_BIST_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a1, b1, s1, a3, b3, s3;
  logic       cin1, co1, cin3, co3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [5:0] err1, err3;
  logic [4:0] fv1, fv3;

  int mode1 = 0, mode3 = 0;
  int xtab [N];
  int errors = 0, checks = 0;
  int sel = 0;

  adder2_bist #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1), .cin_o(cin1),
    .s_i(s1), .cout_i(co1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1));

  adder2_bist #(.WIDTH(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3), .cin_o(cin3),
    .s_i(s3), .cout_i(co3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_vec(fv3));

  // mode: 0 good adder, 1 S[0] stuck at 0, 2 Cout stuck at 0, 3 random corruption table
  function automatic int fault(input int mode, input int x, input int g);
    case (mode)
      1:       return g & 6;
      2:       return g & 3;
      3:       return g ^ x;
      default: return g;
    endcase
  endfunction

  always_comb begin
    logic [2:0] r;
    r = 3'(fault(mode1, xtab[{cin1, b1, a1}], int'(a1) + int'(b1) + int'(cin1)));
    {co1, s1} = r;
  end

  always_comb begin
    logic [2:0] r;
    r = 3'(fault(mode3, xtab[{cin3, b3, a3}], int'(a3) + int'(b3) + int'(cin3)));
    {co3, s3} = r;
  end

  logic       m_busy, m_done, m_pass;
  logic [5:0] m_err;
  logic [4:0] m_fv, m_vec;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_pass = sel ? pass3 : pass1;
  assign m_err  = sel ? err3  : err1;
  assign m_fv   = sel ? fv3   : fv1;
  assign m_vec  = sel ? {cin3, b3, a3} : {cin1, b1, a1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: walk vectors in sweep order with plain arithmetic
  task automatic model(input int mode, input int settle,
                       output int e, output int fv, output int edge_n);
    int last;
    e = 0; fv = 0; last = N-1;
    for (int k = 0; k < N; k++) begin
      int g, got;
      g   = (k % 4) + ((k / 4) % 4) + (k / 16);
      got = fault(mode, xtab[k], g);
      if (got != g) begin
        e++;
        if (e == 1) fv = k;
        if (STOP) begin
          last = k;
          break;
        end
      end
    end
    edge_n = (last + 1) * (settle + 1);
  endtask

  task automatic set_start(input bit v);
    if (sel != 0) start3 = v;
    else          start1 = v;
  endtask

  task automatic check_run(input string nm, input int s, input int mode,
                           input int exp_err, input int exp_fv, input int exp_edge,
                           input bit pulses);
    int  settle, edges, busy_n, budget;
    bit  finished;
    settle = s ? 3 : 1;
    @(negedge clk);
    sel = s;
    if (s != 0) mode3 = mode;
    else        mode1 = mode;
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    edges = 0; busy_n = 0; finished = 1'b0;
    if (m_busy) busy_n++;
    budget = N * (settle + 1) + 20;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (m_done) begin
        finished = 1'b1;
        break;
      end
      if (m_busy) busy_n++;
      set_start(pulses && (edges == 5 || edges == 20 || edges == 77));
    end
    set_start(1'b0);
    if (!finished) chk({nm, " timeout"}, 0, 1);
    chk({nm, " done_edge"}, edges, exp_edge);
    chk({nm, " busy_cycles"}, busy_n, exp_edge);
    chk({nm, " err_cnt"}, int'(m_err), exp_err);
    chk({nm, " pass"}, int'(m_pass), (exp_err == 0) ? 1 : 0);
    if (exp_err != 0) chk({nm, " fail_vec"}, int'(m_fv), exp_fv);
    chk({nm, " last_vec"}, int'(m_vec), exp_edge / (settle + 1) - 1);
    repeat (2) @(posedge clk);
    #1 chk({nm, " done_hold"}, int'(m_done), 1);
  endtask

  typedef struct {
    string nm;
    int    mode;
    int    exp_err;
    int    exp_fv;
    int    exp_edge;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int e, fv, ed;

    tbl[0] = '{"golden", 0, 0, 0, 64};
    tbl[1] = '{"s0_stuck", 1, STOP ? 1 : 16, 1, STOP ? 4 : 64};
    tbl[2] = '{"cout_stuck", 2, STOP ? 1 : 16, 7, STOP ? 16 : 64};
    for (int k = 0; k < N; k++) xtab[k] = 0;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("reset vec", int'(m_vec), 0);
      chk("reset busy/done/pass", int'({m_busy, m_done, m_pass}), 0);
      chk("reset err/fv", int'({m_err, m_fv}), 0);
    end
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 3; i++)
      check_run(tbl[i].nm, 0, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_fv, tbl[i].exp_edge, 1'b0);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < N; k++)
        xtab[k] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      model(3, (r == 4) ? 3 : 1, e, fv, ed);
      check_run($sformatf("rand%0d", r), (r == 4) ? 1 : 0, 3, e, fv, ed, 1'b0);
    end

    check_run("s3_golden_pulses", 1, 0, 0, 0, 128, 1'b1);
    model(1, 3, e, fv, ed);
    check_run("s3_s0_stuck", 1, 1, e, fv, ed, 1'b0);
    check_run("s3_rerun_clear", 1, 0, 0, 0, 128, 1'b0);

    @(negedge clk);
    sel = 0; mode1 = 0;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_vec == 5'd10) break;
      @(posedge clk);
      #1;
    end
    chk("midrst reached idx10", int'(m_vec), 10);
    #2 rst = 1'b1;
    #1;
    chk("midrst vec", int'(m_vec), 0);
    chk("midrst busy/done/pass", int'({m_busy, m_done, m_pass}), 0);
    chk("midrst err/fv", int'({m_err, m_fv}), 0);
    @(negedge clk) rst = 1'b0;
    check_run("after_reset", 0, 0, 0, 0, 64, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
